// File: rtl/checker_pkg.sv
// Shared types and defaults for the register result checker.
package checker_pkg;

  localparam int IDX_W       = 4;
  localparam int CYC_W       = 32;
  localparam int NREGS_DEF   = 6;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 2500;
  localparam int STABLE_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN,
    ST_PASS,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/checker_shadow_rf.sv
// Small register table, all entries visible in parallel; used for both the
// processor shadow copy and the expected-value table.
module checker_shadow_rf
  import checker_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         we,
  input  logic [IDX_W-1:0]             waddr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [NREGS-1:0][DATA_W-1:0] regs
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

  // Indices at or beyond NREGS match no entry and are dropped.
  always_comb begin
    regs_d = regs_q;
    if (clr) begin
      regs_d = '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we && (waddr == IDX_W'(i))) regs_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign regs = regs_q;

endmodule

// File: rtl/result_checker.sv
// Watches register writebacks during a run, then scans them against an
// expected table. Optional early exit on stable match: CHECKER_EARLY_EXIT_EN.
module result_checker
  import checker_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int STABLE  = STABLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  fail_addr,
  output logic [DATA_W-1:0] fail_got,
  output logic [NREGS-1:0]  match_mask,
  output logic [CYC_W-1:0]  cycles
);

  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NREGS - 1);

  state_e                       state_q, state_d;
  logic [CYC_W-1:0]             cycles_q, cycles_d;
  logic [IDX_W-1:0]             scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]             fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]            fail_got_q, fail_got_d;
  logic [DATA_W-1:0]            cur_shadow, cur_exp;
  logic [NREGS-1:0][DATA_W-1:0] shadow_regs, exp_regs;
  logic                         shadow_clr, shadow_we, exp_table_we, early_exit;

  checker_shadow_rf #(.NREGS(NREGS), .DATA_W(DATA_W)) u_shadow (
    .clk   (clk),
    .reset (reset),
    .clr   (shadow_clr),
    .we    (shadow_we),
    .waddr (wb_addr),
    .wdata (wb_data),
    .regs  (shadow_regs)
  );

  checker_shadow_rf #(.NREGS(NREGS), .DATA_W(DATA_W)) u_expected (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .we    (exp_table_we),
    .waddr (exp_addr),
    .wdata (exp_data),
    .regs  (exp_regs)
  );

  always_comb begin
    match_mask = '0;
    cur_shadow = '0;
    cur_exp    = '0;
    for (int i = 0; i < NREGS; i++) begin
      match_mask[i] = (shadow_regs[i] == exp_regs[i]);
      if (scan_idx_q == IDX_W'(i)) begin
        cur_shadow = shadow_regs[i];
        cur_exp    = exp_regs[i];
      end
    end
  end

`ifdef CHECKER_EARLY_EXIT_EN
  localparam int                STAB_W      = $clog2(STABLE + 1);
  localparam logic [STAB_W-1:0] STABLE_LAST = STAB_W'(STABLE - 1);

  logic [STAB_W-1:0] stab_q, stab_d;

  always_comb begin
    stab_d = '0;
    if ((state_q == ST_RUN) && (&match_mask)) stab_d = stab_q + 1'b1;
  end

  assign early_exit = (state_q == ST_RUN) && (&match_mask) && (stab_q == STABLE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stab_q <= '0;
    else        stab_q <= stab_d;
  end
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cycles_d     = cycles_q;
    scan_idx_d   = scan_idx_q;
    fail_addr_d  = fail_addr_q;
    fail_got_d   = fail_got_q;
    shadow_clr   = 1'b0;
    shadow_we    = 1'b0;
    exp_table_we = 1'b0;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        // Expected table is only writable from IDLE; a restart keeps it.
        exp_table_we = exp_we && (state_q == ST_IDLE);
        if (start) begin
          state_d     = ST_RUN;
          cycles_d    = '0;
          shadow_clr  = 1'b1;
          fail_addr_d = '0;
          fail_got_d  = '0;
        end
      end
      ST_RUN: begin
        shadow_we = wb_en;
        if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
        if ((cycles_q == TIMEOUT_LAST) || early_exit) begin
          state_d    = ST_SCAN;
          scan_idx_d = '0;
        end
      end
      ST_SCAN: begin
        if (cur_shadow != cur_exp) begin
          state_d     = ST_FAIL;
          fail_addr_d = scan_idx_q;
          fail_got_d  = cur_shadow;
        end else if (scan_idx_q == LAST_IDX) begin
          state_d = ST_PASS;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cycles_q    <= '0;
      scan_idx_q  <= '0;
      fail_addr_q <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      scan_idx_q  <= scan_idx_d;
      fail_addr_q <= fail_addr_d;
      fail_got_q  <= fail_got_d;
    end
  end

  assign busy      = (state_q == ST_RUN) || (state_q == ST_SCAN);
  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass      = (state_q == ST_PASS);
  assign fail_addr = fail_addr_q;
  assign fail_got  = fail_got_q;
  assign cycles    = cycles_q;

endmodule
